// File: rtl/outport_uart_tx.sv
// -----------------------------------------------------------------------------
// outport_uart_tx
//
// Watches the CPU's OUT.PORT load strobe. Each rising edge of OUTPORTin captures
// the 32-bit bus word into a small circular word FIFO. A UART transmitter drains
// the FIFO and sends every word as four 8N1 bytes, least significant byte first,
// so that `out` instructions become visible off-chip.
//
// Ports:
//   Clock        in   system clock, all state changes on posedge
//   clear        in   synchronous active-high reset (aborts any frame in flight)
//   OUTPORTin    in   OUT.PORT load strobe (level; rising edge = one push)
//   outportData  in   [31:0] bus word, sampled on the strobe's rising edge
//   tx           out  UART serial line, idle high, driven from a flop
//   txBusy       out  high while a word is being serialized
//   fifoFull     out  FIFO holds FIFO_DEPTH words
//   fifoEmpty    out  FIFO holds no words
//   overflow     out  sticky: a push was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module outport_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        OUTPORTin,
  input  logic [31:0] outportData,
  output logic        tx,
  output logic        txBusy,
  output logic        fifoFull,
  output logic        fifoEmpty,
  output logic        overflow
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Edge detect and FIFO state
  logic              strobe_q;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Transmitter state
  logic [1:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [1:0]        byte_q, byte_d;
  logic [31:0]       shift_q, shift_d;

  // Registered outputs
  logic tx_q, tx_d;
  logic busy_q, full_q, empty_q, ovf_q, ovf_d;

  logic push_s, pop_s, accept_s, drop_s, baud_done_s;

  // Push/pop decisions: a pop in the same cycle frees the slot a full-FIFO push needs
  always_comb begin
    push_s      = OUTPORTin & ~strobe_q;
    pop_s       = (state_q == ST_IDLE) && (count_q != CNT_ZERO);
    accept_s    = push_s && ((count_q != CNT_FULL) || pop_s);
    drop_s      = push_s && (count_q == CNT_FULL) && !pop_s;
    baud_done_s = (baud_q == BAUD_LAST);
  end

  // FIFO pointer, occupancy and sticky overflow next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | drop_s;
    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Transmitter FSM next-state: START / 8 x DATA / STOP per byte, four bytes per word
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          shift_d = mem_q[rd_ptr_q];
          byte_d  = 2'd0;
          baud_d  = {BAUD_W{1'b0}};
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_done_s) begin
          baud_d  = {BAUD_W{1'b0}};
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          baud_d  = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_done_s) begin
          baud_d  = {BAUD_W{1'b0}};
          // After eight shifts the next byte sits in shift_q[7:0]
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d  = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_done_s) begin
          baud_d = {BAUD_W{1'b0}};
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = {BAUD_W{1'b0}};
      end
    endcase
  end

  // Line level for the current FSM state; registered below so tx never glitches
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // Word storage; contents need no reset because the pointers define validity
  always_ff @(posedge Clock) begin
    if (accept_s) begin
      mem_q[wr_ptr_q] <= outportData;
    end
  end

  // Edge detector, FIFO bookkeeping and status flags
  always_ff @(posedge Clock) begin
    if (clear) begin
      strobe_q <= 1'b0;
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= CNT_ZERO;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      strobe_q <= OUTPORTin;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // Flags follow the settled count, one cycle after it changes
      full_q   <= (count_q == CNT_FULL);
      empty_q  <= (count_q == CNT_ZERO);
      ovf_q    <= ovf_d;
    end
  end

  // Transmitter registers and registered line/busy outputs
  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
      baud_q  <= {BAUD_W{1'b0}};
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      shift_q <= 32'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= (state_q != ST_IDLE);
    end
  end

  assign tx        = tx_q;
  assign txBusy    = busy_q;
  assign fifoFull  = full_q;
  assign fifoEmpty = empty_q;
  assign overflow  = ovf_q;

endmodule
